// File: rtl/and_resp_checker_pkg.sv
// Shared types and helpers for the AND-gate response checker.
package and_chk_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_CHECK  = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  function automatic logic exp_and(input logic a, input logic b);
    return a & b;
  endfunction

endpackage

// File: rtl/and_resp_checker_if.sv
// Observation/result bundle between the gate-under-test side and the response checker.
interface and_resp_if #(
  parameter int ERR_W = 8
);
  logic             clear;
  logic             a_in;
  logic             b_in;
  logic             y_in;
  logic [3:0]       covered;
  logic [ERR_W-1:0] err_count;
  logic             mismatch_pulse;
  logic             done;
  logic             pass;
  logic             fail;

  modport master (
    output clear, a_in, b_in, y_in,
    input  covered, err_count, mismatch_pulse, done, pass, fail
  );

  modport slave (
    input  clear, a_in, b_in, y_in,
    output covered, err_count, mismatch_pulse, done, pass, fail
  );
endinterface

// File: rtl/and_resp_checker_sync.sv
// Two-flop synchroniser for one asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/and_resp_checker.sv
// Response checker: waits for {a,b} to settle, compares y against a&b, tracks coverage and errors.
module and_resp_checker
  import and_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  and_resp_if.slave  bus
);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  logic a_s, b_s, y_s;

  sync_2ff u_sync_a (.clk(clk), .rst_n(rst_n), .d(bus.a_in), .q(a_s));
  sync_2ff u_sync_b (.clk(clk), .rst_n(rst_n), .d(bus.b_in), .q(b_s));
  sync_2ff u_sync_y (.clk(clk), .rst_n(rst_n), .d(bus.y_in), .q(y_s));

  logic [1:0]       vec, vec_q;
  logic             chg;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             armed, exp_q;
  logic [3:0]       covered;
  logic [ERR_W-1:0] err_count;
  logic             pulse, done, fail;
  logic             hit;
  logic [3:0]       cov_nxt;

  assign vec = {a_s, b_s};
  assign chg = (vec != vec_q);

  // A vector that changed this cycle is never checked or marked covered.
  always_comb begin
    hit     = 1'b0;
    cov_nxt = covered;
    case (state)
      ST_CHECK: if (!chg) begin
        cov_nxt[vec] = 1'b1;
        hit          = (y_s != exp_and(a_s, b_s));
      end
      ST_HOLD:  hit = !chg && armed && (y_s != exp_q);
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vec_q <= '0;
    else        vec_q <= vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SETTLE;
      cnt       <= '0;
      armed     <= 1'b0;
      exp_q     <= 1'b0;
      covered   <= '0;
      err_count <= '0;
      pulse     <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
    end else if (bus.clear) begin
      state     <= ST_SETTLE;
      cnt       <= '0;
      armed     <= 1'b0;
      exp_q     <= 1'b0;
      covered   <= '0;
      err_count <= '0;
      pulse     <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      pulse   <= hit;
      covered <= cov_nxt;
      if (cov_nxt == 4'hF) done <= 1'b1;
      if (hit) begin
        fail <= 1'b1;
        if (err_count != '1) err_count <= err_count + ERR_W'(1);
      end
      case (state)
        ST_SETTLE: begin
          if (chg) begin
            cnt <= '0;
          end else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            cnt   <= '0;
            state <= ST_CHECK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (chg) begin
            cnt   <= '0;
            state <= ST_SETTLE;
          end else begin
            exp_q <= exp_and(a_s, b_s);
            armed <= !hit;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (chg) begin
            cnt   <= '0;
            state <= ST_SETTLE;
          end else if (hit) begin
            armed <= 1'b0;
          end
        end
        default: state <= ST_SETTLE;
      endcase
    end
  end

  assign bus.covered        = covered;
  assign bus.err_count      = err_count;
  assign bus.mismatch_pulse = pulse;
  assign bus.done           = done;
  assign bus.pass           = done && (err_count == '0);
  assign bus.fail           = fail;
endmodule

// File: tb/tb_and_resp_checker.sv
// Directed bench for and_resp_checker: an ERR_W=8 and an ERR_W=2 instance see identical stimulus.
module tb_and_resp_checker;
  logic clk, rst_n;
  logic a, b, y, clr;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned p8 = 0, p2 = 0;

  and_resp_if #(.ERR_W(8)) bus8 ();
  and_resp_if #(.ERR_W(2)) bus2 ();

  assign bus8.a_in = a;  assign bus8.b_in = b;  assign bus8.y_in = y;  assign bus8.clear = clr;
  assign bus2.a_in = a;  assign bus2.b_in = b;  assign bus2.y_in = y;  assign bus2.clear = clr;

  and_resp_checker #(.SETTLE_CYCLES(4), .ERR_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  and_resp_checker #(.SETTLE_CYCLES(4), .ERR_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus8.mismatch_pulse) p8 <= p8 + 1;
    if (bus2.mismatch_pulse) p2 <= p2 + 1;
  end

  typedef struct {
    logic        a, b, y;
    int unsigned hold;
    logic [3:0]  cov;
    int unsigned err;
    logic        done, pass, fail;
    int unsigned pulses;
  } row_t;

  row_t rows [8];

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic check8(input string nm, input logic [3:0] cov, input int unsigned err,
                        input logic dn, input logic ps, input logic fl);
    check({nm, ".covered"}, int'(bus8.covered), int'(cov));
    check({nm, ".err"},     int'(bus8.err_count), err);
    check({nm, ".done"},    int'(bus8.done), int'(dn));
    check({nm, ".pass"},    int'(bus8.pass), int'(ps));
    check({nm, ".fail"},    int'(bus8.fail), int'(fl));
  endtask

  task automatic check_zero(input string nm);
    check8(nm, 4'h0, 0, 1'b0, 1'b0, 1'b0);
    check({nm, ".pulse8"}, int'(bus8.mismatch_pulse), 0);
    check({nm, ".cov2"},   int'(bus2.covered), 0);
    check({nm, ".err2"},   int'(bus2.err_count), 0);
    check({nm, ".fail2"},  int'(bus2.fail), 0);
    check({nm, ".done2"},  int'(bus2.done), 0);
    check({nm, ".pulse2"}, int'(bus2.mismatch_pulse), 0);
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  initial begin
    int unsigned snap, snap2;
    // correct gate
    rows[0] = '{1'b0, 1'b0, 1'b0, 12, 4'h1, 0, 1'b0, 1'b0, 1'b0, 0};
    rows[1] = '{1'b0, 1'b1, 1'b0, 12, 4'h3, 0, 1'b0, 1'b0, 1'b0, 0};
    rows[2] = '{1'b1, 1'b0, 1'b0, 12, 4'h7, 0, 1'b0, 1'b0, 1'b0, 0};
    rows[3] = '{1'b1, 1'b1, 1'b1, 12, 4'hF, 0, 1'b1, 1'b1, 1'b0, 0};
    // stuck-at-0 output
    rows[4] = '{1'b0, 1'b0, 1'b0, 12, 4'h1, 0, 1'b0, 1'b0, 1'b0, 0};
    rows[5] = '{1'b0, 1'b1, 1'b0, 12, 4'h3, 0, 1'b0, 1'b0, 1'b0, 0};
    rows[6] = '{1'b1, 1'b0, 1'b0, 12, 4'h7, 0, 1'b0, 1'b0, 1'b0, 0};
    rows[7] = '{1'b1, 1'b1, 1'b0, 12, 4'hF, 1, 1'b1, 1'b0, 1'b1, 1};

    a = 1'b0; b = 1'b0; y = 1'b0; clr = 1'b0; rst_n = 1'b0;
    tick(2);
    check_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        pulse_clear();
        check_zero("clear_t1");
      end
      snap = p8;
      a = rows[i].a; b = rows[i].b; y = rows[i].y;
      tick(rows[i].hold);
      check8($sformatf("row%0d", i), rows[i].cov, rows[i].err, rows[i].done,
             rows[i].pass, rows[i].fail);
      check($sformatf("row%0d.pulses", i), p8 - snap, rows[i].pulses);
    end

    // glitch on y while the vector is still settling
    pulse_clear();
    a = 1'b0; b = 1'b0; y = 1'b0;
    tick(12);
    snap = p8;
    a = 1'b1; b = 1'b1; y = 1'b0;
    tick(3);
    y = 1'b1;
    tick(12);
    check8("glitch", 4'b1001, 0, 1'b0, 1'b0, 1'b0);
    check("glitch.pulses", p8 - snap, 0);

    // fault appears in HOLD with no input change: one error only
    snap = p8;
    y = 1'b0;
    tick(20);
    check8("hold_fault", 4'b1001, 1, 1'b0, 1'b0, 1'b1);
    check("hold_fault.pulses", p8 - snap, 1);
    y = 1'b1;
    tick(2);

    // saturation on the narrow counter
    pulse_clear();
    snap = p8; snap2 = p2;
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) begin a = 1'b1; b = 1'b1; y = 1'b0; end
      else            begin a = 1'b0; b = 1'b0; y = 1'b1; end
      tick(12);
    end
    check("sat.err2",    int'(bus2.err_count), 3);
    check("sat.fail2",   int'(bus2.fail), 1);
    check("sat.pulses2", p2 - snap2, 5);
    check("sat.err8",    int'(bus8.err_count), 5);
    check("sat.pulses8", p8 - snap, 5);
    check("sat.pass8",   int'(bus8.pass), 0);
    pulse_clear();
    check_zero("clear_sat");

    // async reset mid-settle
    tick(12);
    check("pre_rst.err2", int'(bus2.err_count), 1);
    a = 1'b0; b = 1'b0; y = 1'b0;
    tick(4);
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");

    // bounce on b right out of reset
    a = 1'b0; b = 1'b1; y = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(3);
    b = 1'b0;
    tick(3);
    b = 1'b1;
    check("bounce.cov_mid", int'(bus8.covered), 0);
    tick(15);
    check8("bounce", 4'b0010, 0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
